// File: rtl/apb_master_mc.sv
// rtl/apb_master_mc.sv - APB4 master converting single-cycle requests into SETUP/ACCESS bus cycles
//
// Optional feature macro: APB_TIMEOUT_EN (aborts ACCESS after TIMEOUT_CYCLES wait states).
//
// Ports:
//   pclk, presetn                  clock, asynchronous active-low reset
//   transfer, write_read           request valid, direction (1 = write)
//   addr_in, wdata_in, strb_in     request address, write data, byte strobes
//   psel, penable, pwrite          APB control (psel one-hot per completer)
//   paddr, pwdata, pstrb           APB address/data/strobes (pstrb 0 on reads)
//   prdata, pready, pslverr        per-completer responses, slave i at slice i
//   rdata_out                      data of the last successful read
//   transfer_done, error           registered single-cycle completion pulse and status
module apb_master_mc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             transfer,
    input  logic                             write_read,
    input  logic [ADDR_WIDTH-1:0]            addr_in,
    input  logic [DATA_WIDTH-1:0]            wdata_in,
    input  logic [DATA_WIDTH/8-1:0]          strb_in,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic [DATA_WIDTH-1:0]            rdata_out,
    output logic                             transfer_done,
    output logic                             error
);

    localparam int SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    generate
        if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) ||
            NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("apb_master_mc: unsupported parameter combination");
        end
    endgenerate

    // DERR reports a decode error for a request accepted on the completion
    // edge of a previous transfer, whose own done pulse occupies the next cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SEL_BITS-1:0]   req_idx;
    logic                  req_valid;
    logic [SEL_BITS-1:0]   cur_idx;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  accept;
    logic                  timeout;
    logic                  done_nxt;
    logic                  error_nxt;

    assign req_idx   = addr_in[SEL_LSB +: SEL_BITS];
    assign req_valid = ({{(32-SEL_BITS){1'b0}}, req_idx} < NUM_SLAVES);

    // Observe only the selected completer's response.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_idx == SEL_BITS'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // New requests are taken only when idle or on the completing ACCESS edge.
    assign accept = transfer && ((state == IDLE) || ((state == ACCESS) && sel_ready));

`ifdef APB_TIMEOUT_EN
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOUT_W-1:0] tcnt;

    // Abort on the edge that would bring the wait count to TIMEOUT_CYCLES.
    assign timeout = (state == ACCESS) && !sel_ready &&
                     (tcnt == TOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tcnt <= '0;
        end else if (state_nxt == SETUP) begin
            tcnt <= '0;
        end else if ((state == ACCESS) && !sel_ready && !timeout) begin
            tcnt <= tcnt + TOUT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && req_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    if (accept) begin
                        state_nxt = req_valid ? SETUP : DERR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            DERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: bus select/enable from state, next values of the status pulses.
    always_comb begin
        psel      = '0;
        penable   = 1'b0;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        if ((state == SETUP) || (state == ACCESS)) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                psel[i] = (cur_idx == SEL_BITS'(i));
            end
        end
        if (state == ACCESS) begin
            penable = 1'b1;
        end
        case (state)
            IDLE: begin
                if (accept && !req_valid) begin
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    done_nxt  = 1'b1;
                    error_nxt = sel_err;
                end else if (timeout) begin
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                end
            end
            DERR: begin
                done_nxt  = 1'b1;
                error_nxt = 1'b1;
            end
            default: begin
                done_nxt  = 1'b0;
                error_nxt = 1'b0;
            end
        endcase
    end

    // Request latch and response capture. Bus fields hold while idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cur_idx       <= '0;
            paddr         <= '0;
            pwrite        <= 1'b0;
            pwdata        <= '0;
            pstrb         <= '0;
            rdata_out     <= '0;
            transfer_done <= 1'b0;
            error         <= 1'b0;
        end else begin
            transfer_done <= done_nxt;
            error         <= error_nxt;
            if ((state == ACCESS) && sel_ready && !pwrite && !sel_err) begin
                rdata_out <= sel_rdata;
            end
            if (accept && req_valid) begin
                cur_idx <= req_idx;
                paddr   <= addr_in;
                pwrite  <= write_read;
                pwdata  <= wdata_in;
                pstrb   <= write_read ? strb_in : {STRB_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: doc/apb_master_mc.md
# apb_master_mc

Parametrised APB4 master for the APB verification environment: it converts a single-cycle request interface (transfer/write_read/addr_in/wdata_in/strb_in) into APB SETUP/ACCESS phases toward up to NUM_SLAVES completers. It decodes addresses into one-hot psel, muxes per-slave prdata/pready/pslverr, and supports back-to-back transfers. It reports completion with transfer_done, error and rdata_out, and can optionally abort hung transfers with a wait-state timeout.

## Interface
- ADDR_WIDTH, 32, paddr/addr_in width
- DATA_WIDTH, 32, data width; must be 8, 16 or 32
- NUM_SLAVES, 4, number of completers, range 1..16
- SEL_LSB, 28, LSB of slave-index field in addr_in; field width SEL_BITS = max(1, $clog2(NUM_SLAVES))
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort; used only with APB_TIMEOUT_EN
- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  reset; asynchronous assert, active-low
- transfer  in  1  request valid
- write_read  in  1  1 = write, 0 = read
- addr_in  in  ADDR_WIDTH  request address
- wdata_in  in  DATA_WIDTH  write data
- strb_in  in  DATA_WIDTH/8  write byte strobes
- psel  out  NUM_SLAVES  one-hot completer select
- penable  out  1  ACCESS phase
- pwrite  out  1  transfer direction
- paddr  out  ADDR_WIDTH  address
- pwdata  out  DATA_WIDTH  write data
- pstrb  out  DATA_WIDTH/8  strobes; forced 0 on reads
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error
- rdata_out  out  DATA_WIDTH  last successful read data
- transfer_done  out  1  one-cycle completion pulse
- error  out  1  valid with transfer_done: pslverr, decode error or timeout

## Operation
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-transfer drops psel/penable immediately and produces no transfer_done.
- Request acceptance: transfer sampled high in IDLE, or in ACCESS on the completion edge. addr_in, write_read, wdata_in and strb_in latch on acceptance. Inputs are not re-sampled while busy; transfer high in SETUP, or in ACCESS before completion, is ignored.
- Decode: idx = addr_in[SEL_LSB +: SEL_BITS]. If idx >= NUM_SLAVES, no bus cycle occurs and the next cycle has transfer_done=1, error=1.
- IDLE: psel=0, penable=0. A valid accepted request goes to SETUP.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the latched request. Always goes to ACCESS on the next edge.
- ACCESS: penable=1. Only pready[idx], pslverr[idx] and prdata slice idx are observed. On pready[idx]=1, the next cycle has transfer_done=1 and error=pslverr[idx].
  - For a read with pslverr=0, rdata_out <= prdata slice. Otherwise rdata_out holds its value.
  - If transfer=1 on that edge, go to SETUP with the new request; psel stays high if the same slave is selected. Otherwise go to IDLE.
- paddr, pwrite, pwdata and pstrb hold their values in IDLE (no gratuitous toggling).

## Timing
- Zero-wait transfer: accept at edge N; SETUP visible after N; ACCESS after N+1; pready sampled at N+2; transfer_done high during cycle after N+2. Latency is 3 cycles + wait states.
- Back-to-back: 2 cycles per transfer (SETUP + ACCESS), with no IDLE gap.
- Decode error: transfer_done 1 cycle after acceptance.
- transfer_done and error are registered, single-cycle pulses.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter counts ACCESS cycles with pready[idx]=0.
  - When it reaches TIMEOUT_CYCLES: psel/penable drop, state goes to IDLE, and transfer_done=1, error=1 next cycle. A request on that edge is not accepted.
  - The counter clears on entry to SETUP.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely; no counter logic is present.

## Test plan
- Zero-wait write: addr 0x1000_0040, wdata 0xDEAD_BEEF, strb 0xF -> psel=4'b0010, pstrb=0xF, transfer_done 3 cycles after accept, error=0.
- Read with 2 wait states from slave 2 returning 0x1234_5678 -> pstrb=0, rdata_out=0x1234_5678, done 5 cycles after accept.
- Read with pslverr=1 at completion -> error=1, rdata_out keeps its previous value.
- Three back-to-back writes to slaves 0, 0, 3 -> no IDLE between them, done pulses every 2 cycles, psel switches 0001 -> 0001 -> 1000.
- NUM_SLAVES=3, addr 0x3000_0000 -> no psel, done=1 and error=1 one cycle after accept.
- With APB_TIMEOUT_EN and pready held 0 -> abort after 16 ACCESS cycles, error=1. Separately, presetn pulse mid-ACCESS -> all outputs 0, no done pulse.
